program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
Program sequencer for the 4-bit processor. It generates the 8-bit program-memory fetch address and holds the program counter. It services jump, conditional jump (on computational_unit r_eq_0), call/return and halt controls from the instruction decoder. It sits between the instruction decoder and program memory and is the block that sequences the computational unit.

Parameters:
STACK_DEPTH, 4, number of return-address entries (2..8)
PC_W, 8, program counter / pm_addr width

Ports:
clk  input  1  system clock, all state updates on rising edge
sync_reset  input  1  asynchronous active-high reset
hold  input  1  stall: freeze pc, stack and state this cycle
jmp  input  1  unconditional jump
jmp_nz  input  1  conditional jump, taken iff r_eq_0 == 0
r_eq_0  input  1  zero flag from computational_unit
call  input  1  push return address, then jump
ret  input  1  pop return address into pc
halt  input  1  stop sequencing
jmp_nibble  input  4  target low nibble (ir[3:0])
pm_addr  output  PC_W  fetch address to program memory (combinational)
pc  output  PC_W  registered program counter
stack_depth  output  4  entries currently on stack
stack_err  output  1  sticky overflow/underflow flag
halted  output  1  high in S_HALT

Behaviour:
- Reset is asynchronous. While sync_reset=1: state=S_START, pc=0, stack_depth=0, stack_err=0, halted=0, pm_addr=0, stack contents don't-care. Reset asserted mid-operation (including mid-call) aborts immediately; no pending push/pop completes.
- FSM states S_START, S_RUN, S_HALT:
  - S_START: pm_addr=0. All controls ignored. Next edge goes to S_RUN with pc<=0 (hold ignored). Address 0 is therefore fetched exactly once after reset.
  - S_RUN: pm_addr=next address (below). Each non-hold edge: pc<=pm_addr.
  - S_HALT: entered on an edge in S_RUN with halt=1 and hold=0, with pc<=pc. halted=1, pm_addr=pc, all controls ignored. Exit only by reset.
- Next-address priority in S_RUN (first match wins): hold -> pc; ret -> stack top; call -> target; jmp -> target; jmp_nz & !r_eq_0 -> target; else pc+1.
  - target = {pc[7:4], jmp_nibble}.
  - halt is evaluated alongside jump/increment: the next address still applies on the halting edge (pc<=pm_addr), and the FSM then enters S_HALT.
- Increment wraps 8'hFF -> 8'h00 silently.
- hold=1: pm_addr=pc; pc, stack, stack_depth, state unchanged; stack_err not set.
- call: pushes pc+1 (wrapped) and jumps. If stack_depth==STACK_DEPTH: the jump still occurs, the push is dropped, depth is unchanged and stack_err<=1.
- ret: pops; pm_addr=top entry, depth-1. If depth==0: pc+1 is used instead and stack_err<=1.
- ret and call together: ret wins and call is ignored (no push).
- stack_err is cleared only by reset.
- All outputs are registered except pm_addr.

Optional Feature:
PS_STACK_EN
- Defined: call/ret stack as above.
- Undefined: no stack storage. call behaves as jmp, ret is ignored (pc+1), stack_depth=0, stack_err=0 constantly.

Decomposition:
- Shared package ps_pkg: state encoding (S_START=2'd0, S_RUN=2'd1, S_HALT=2'd2), PC_W, STACK_DEPTH default, RESET_ADDR=8'h00.
- One sub-module: ps_return_stack (LIFO with push, pop, top, depth, full, empty; async reset). Instantiated only under PS_STACK_EN.

Test Plan:
- Reset release, no controls: pm_addr 00 (S_START), then 01, 02, 03; pc lags pm_addr by one cycle.
- pc=8'h3A, jmp=1, jmp_nibble=4'h5 -> pm_addr=8'h35; jmp_nz=1 with r_eq_0=1 at pc=35 -> 36; with r_eq_0=0 -> 8'h35.
- pc=8'hFF with no controls -> pm_addr=8'h00, no error.
- Five nested calls with STACK_DEPTH=4 from pc=10,20,30,40,50 -> depth 4, stack_err=1 after the 5th call, jump still taken. Four rets return 41,31,21,11; a 5th ret gives pc+1 with stack_err remaining 1.
- hold=1 for 3 cycles at pc=8'h22 with call=1 -> pm_addr=22 throughout, depth unchanged; on release the call executes once.
- halt at pc=8'h07 -> halted=1, pm_addr frozen at 8'h08; jmp ignored. Async reset asserted mid-cycle -> pm_addr=0 immediately; on release, normal restart from 00.

Source files
------------

// File: rtl/ps_pkg.sv
// Shared types and defaults for the program sequencer.
// The optional call/return stack is enabled by defining PS_STACK_EN.
package ps_pkg;

    localparam int DEF_PC_W        = 8;
    localparam int DEF_STACK_DEPTH = 4;

    localparam logic [7:0] RESET_ADDR = 8'h00;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } ps_state_t;

endpackage

// File: rtl/ps_return_stack.sv
// Return-address LIFO for call/ret; used only when PS_STACK_EN is defined.
// Push on full and pop on empty are ignored here; the caller flags them.
module ps_return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_top,
    output logic [3:0]   o_depth,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [3:0]    r_depth;
    logic [AW-1:0] w_wr;
    logic [AW-1:0] w_rd;

    assign w_wr    = r_depth[AW-1:0];
    assign w_rd    = w_wr - AW'(1);
    assign o_full  = (r_depth == 4'(DEPTH));
    assign o_empty = (r_depth == 4'd0);
    assign o_top   = o_empty ? '0 : r_mem[w_rd];
    assign o_depth = r_depth;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_depth <= 4'd0;
        end else if (i_push && !o_full) begin
            r_depth <= r_depth + 4'd1;
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - 4'd1;
        end
    end

    // Contents need no reset: depth alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_push && !o_full) begin
            r_mem[w_wr] <= i_din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch-address sequencer: jump, conditional jump, call/ret and halt.
// Define PS_STACK_EN for the return stack; without it call acts as jmp.
module program_sequencer
    import ps_pkg::*;
#(
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int PC_W        = DEF_PC_W
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic            hold,
    input  logic            jmp,
    input  logic            jmp_nz,
    input  logic            r_eq_0,
    input  logic            call,
    input  logic            ret,
    input  logic            halt,
    input  logic [3:0]      jmp_nibble,
    output logic [PC_W-1:0] pm_addr,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      stack_depth,
    output logic            stack_err,
    output logic            halted
);
    ps_state_t       r_state;
    ps_state_t       w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_inc;
    logic [PC_W-1:0] w_tgt;
    logic            r_halted;
    logic            w_jump;

    assign w_inc  = r_pc + PC_W'(1);
    assign w_tgt  = {r_pc[PC_W-1:4], jmp_nibble};
    assign w_jump = jmp || (jmp_nz && !r_eq_0);

`ifdef PS_STACK_EN
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_err_set;
    logic            r_err;
    logic [PC_W-1:0] w_top;
    logic [3:0]      w_depth;

    ps_return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .i_clk   (clk),
        .i_rst   (sync_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_inc),
        .o_top   (w_top),
        .o_depth (w_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign stack_depth = w_depth;
    assign stack_err   = r_err;
`else
    logic w_unused;

    assign w_unused    = ret;
    assign stack_depth = 4'd0;
    assign stack_err   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        pm_addr     = r_pc;
`ifdef PS_STACK_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_err_set   = 1'b0;
`endif
        unique case (r_state)
            S_START: begin
                pm_addr     = PC_W'(RESET_ADDR);
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!hold) begin
                    if (halt) w_state_nxt = S_HALT;
`ifdef PS_STACK_EN
                    if (ret) begin
                        if (w_empty) begin
                            pm_addr   = w_inc;
                            w_err_set = 1'b1;
                        end else begin
                            pm_addr = w_top;
                            w_pop   = 1'b1;
                        end
                    end else if (call) begin
                        pm_addr = w_tgt;
                        if (w_full) w_err_set = 1'b1;
                        else        w_push    = 1'b1;
                    end else if (w_jump) begin
                        pm_addr = w_tgt;
                    end else begin
                        pm_addr = w_inc;
                    end
`else
                    if (call || w_jump) pm_addr = w_tgt;
                    else                pm_addr = w_inc;
`endif
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_START;
            end
        endcase
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_state  <= S_START;
            r_pc     <= PC_W'(RESET_ADDR);
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_halted <= (w_state_nxt == S_HALT);
            if (r_state == S_START) begin
                r_pc <= PC_W'(RESET_ADDR);
            end else if (r_state == S_RUN && !hold) begin
                r_pc <= pm_addr;
            end
        end
    end

    assign pc     = r_pc;
    assign halted = r_halted;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer; expectations follow PS_STACK_EN.
module tb_program_sequencer;
    import ps_pkg::*;

`ifdef PS_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_HOLD = 7'b1000000;
    localparam logic [6:0] C_JMP  = 7'b0100000;
    localparam logic [6:0] C_JNZ  = 7'b0010000;
    localparam logic [6:0] C_R0   = 7'b0001000;
    localparam logic [6:0] C_CALL = 7'b0000100;
    localparam logic [6:0] C_RET  = 7'b0000010;
    localparam logic [6:0] C_HALT = 7'b0000001;

    typedef struct {
        string      nm;
        logic [6:0] c;
        logic [3:0] nib;
        logic [7:0] pm;
        logic [7:0] pc;
        logic [3:0] dep;
        logic       err;
        logic       hlt;
    } vec_t;

    logic       clk = 1'b0;
    logic       sync_reset = 1'b1;
    logic       hold = 1'b0, jmp = 1'b0, jmp_nz = 1'b0, r_eq_0 = 1'b0;
    logic       call = 1'b0, ret = 1'b0, halt = 1'b0;
    logic [3:0] jmp_nibble = 4'h0;
    logic [7:0] pm_addr, pc;
    logic [3:0] stack_depth;
    logic       stack_err, halted;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] cur = 8'h00;
    logic [3:0] edep = 4'd0;
    logic       eerr = 1'b0;

    program_sequencer dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .hold        (hold),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .r_eq_0      (r_eq_0),
        .call        (call),
        .ret         (ret),
        .halt        (halt),
        .jmp_nibble  (jmp_nibble),
        .pm_addr     (pm_addr),
        .pc          (pc),
        .stack_depth (stack_depth),
        .stack_err   (stack_err),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [6:0] c, logic [3:0] nib,
                                logic [7:0] pm, logic [7:0] p,
                                logic [3:0] dep, logic err, logic hlt);
        vec_t v;
        v.nm = nm; v.c = c; v.nib = nib; v.pm = pm; v.pc = p;
        v.dep = dep; v.err = err; v.hlt = hlt;
        return v;
    endfunction

    function automatic logic [3:0] dd(int n);
        return STK ? 4'(n) : 4'd0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic [6:0] c, logic [3:0] nib);
        {hold, jmp, jmp_nz, r_eq_0, call, ret, halt} = c;
        jmp_nibble = nib;
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        drive(v.c, v.nib);
        #1 chk({v.nm, ".pm_addr"}, 32'(pm_addr), 32'(v.pm));
        @(posedge clk);
        #1;
        chk({v.nm, ".pc"}, 32'(pc), 32'(v.pc));
        chk({v.nm, ".depth"}, 32'(stack_depth), 32'(v.dep));
        chk({v.nm, ".err"}, 32'(stack_err), 32'(v.err));
        chk({v.nm, ".halted"}, 32'(halted), 32'(v.hlt));
        cur = v.pc;
    endtask

    task automatic inc(int n);
        logic [7:0] nx;
        for (int i = 0; i < n; i++) begin
            nx = cur + 8'd1;
            apply(mk("inc", C_NONE, 4'h0, nx, nx, edep, eerr, 1'b0));
        end
    endtask

    task automatic rst_chk(string nm);
        chk({nm, ".pm_addr"}, 32'(pm_addr), 32'h0);
        chk({nm, ".pc"}, 32'(pc), 32'h0);
        chk({nm, ".depth"}, 32'(stack_depth), 32'h0);
        chk({nm, ".err"}, 32'(stack_err), 32'h0);
        chk({nm, ".halted"}, 32'(halted), 32'h0);
    endtask

    vec_t jt[5];
    vec_t ht[3];
    logic [7:0] ex;
    int guard;

    initial begin
        jt[0] = mk("jmp",      C_JMP,          4'h5, 8'h35, 8'h35, 0, 0, 0);
        jt[1] = mk("jnz_zero", C_JNZ | C_R0,   4'h5, 8'h36, 8'h36, 0, 0, 0);
        jt[2] = mk("jnz_take", C_JNZ,          4'h5, 8'h35, 8'h35, 0, 0, 0);
        jt[3] = mk("hold_jmp", C_HOLD | C_JMP, 4'h9, 8'h35, 8'h35, 0, 0, 0);
        jt[4] = mk("jmp_hi",   C_JMP,          4'hF, 8'h3F, 8'h3F, 0, 0, 0);
        ht[0] = mk("halt",      C_HALT,          4'h0, 8'h08, 8'h08, 0, 0, 1);
        ht[1] = mk("halt_jmp",  C_JMP,           4'h3, 8'h08, 8'h08, 0, 0, 1);
        ht[2] = mk("halt_call", C_CALL | C_RET,  4'h3, 8'h08, 8'h08, 0, 0, 1);

        #12 rst_chk("reset");
        @(posedge clk);
        #2 sync_reset = 1'b0;
        apply(mk("start", C_NONE, 4'h0, 8'h00, 8'h00, 0, 0, 0));
        inc(3);
        inc(8'h3A - 3);
        for (int i = 0; i < 5; i++) apply(jt[i]);

        inc(8'hFF - 8'h3F);
        apply(mk("wrap", C_NONE, 4'h0, 8'h00, 8'h00, 0, 0, 0));
        inc(16);

        edep = dd(1);
        apply(mk("call1", C_CALL, 4'hF, 8'h1F, 8'h1F, edep, eerr, 0));
        inc(1);
        edep = dd(2);
        apply(mk("call2", C_CALL, 4'hF, 8'h2F, 8'h2F, edep, eerr, 0));
        inc(1);
        edep = dd(3);
        apply(mk("call3", C_CALL, 4'hF, 8'h3F, 8'h3F, edep, eerr, 0));
        inc(1);
        edep = dd(4);
        apply(mk("call4", C_CALL, 4'hF, 8'h4F, 8'h4F, edep, eerr, 0));
        inc(1);
        eerr = STK;
        apply(mk("call_ovf", C_CALL, 4'h8, 8'h58, 8'h58, edep, eerr, 0));

        ex = STK ? 8'h41 : cur + 8'd1;
        edep = dd(3);
        apply(mk("ret1", C_RET, 4'h0, ex, ex, edep, eerr, 0));
        ex = STK ? 8'h31 : cur + 8'd1;
        edep = dd(2);
        apply(mk("ret2", C_RET, 4'h0, ex, ex, edep, eerr, 0));
        ex = STK ? 8'h21 : cur + 8'd1;
        edep = dd(1);
        apply(mk("ret3", C_RET, 4'h0, ex, ex, edep, eerr, 0));
        ex = STK ? 8'h11 : cur + 8'd1;
        edep = dd(0);
        apply(mk("ret4", C_RET, 4'h0, ex, ex, edep, eerr, 0));
        ex = cur + 8'd1;
        apply(mk("ret_empty", C_RET, 4'h0, ex, ex, edep, eerr, 0));
        ex = STK ? cur + 8'd1 : {cur[7:4], 4'h3};
        apply(mk("ret_call", C_RET | C_CALL, 4'h3, ex, ex, edep, eerr, 0));

        guard = 0;
        while (cur != 8'h22 && guard < 300) begin
            inc(1);
            guard++;
        end
        chk("reach_22", 32'(cur), 32'h22);
        for (int i = 0; i < 3; i++)
            apply(mk("hold_call", C_HOLD | C_CALL, 4'h7, 8'h22, 8'h22, edep, eerr, 0));
        edep = dd(1);
        apply(mk("call_rel", C_CALL, 4'h7, 8'h27, 8'h27, edep, eerr, 0));
        inc(1);

        @(negedge clk);
        drive(C_NONE, 4'h0);
        sync_reset = 1'b1;
        #1 rst_chk("reset2");
        @(posedge clk);
        #2 sync_reset = 1'b0;
        edep = 4'd0;
        eerr = 1'b0;
        apply(mk("start2", C_NONE, 4'h0, 8'h00, 8'h00, 0, 0, 0));
        inc(7);
        for (int i = 0; i < 3; i++) apply(ht[i]);

        @(posedge clk);
        #3 sync_reset = 1'b1;
        drive(C_NONE, 4'h0);
        #1 rst_chk("async_rst");
        @(posedge clk);
        #2 sync_reset = 1'b0;
        apply(mk("start3", C_NONE, 4'h0, 8'h00, 8'h00, 0, 0, 0));
        inc(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
